bus_decoder: RTL
================

BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: write/read data width.
REQ-003 SHALL have parameter MASTERS, default 2: number of downstream ports, 1..8.
REQ-004 SHALL have parameter SELECT_WIDTH, default 2: number of address MSBs used as target index.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4: outstanding-transaction limit, power of two, at least 2.
REQ-006 SHALL have ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_request_valid  input  1  upstream request valid.
- o_request_ready  output  1  upstream request ready.
- i_request_write  input  1  1 = write, 0 = read.
- i_request_address  input  ADDRESS_WIDTH  request address.
- i_request_data  input  DATA_WIDTH  write data.
- o_response_valid  output  1  upstream response valid.
- i_response_ready  input  1  upstream response ready.
- o_response_data  output  DATA_WIDTH  read data.
- o_response_error  output  1  error status.
- o_master_request_valid  output  MASTERS  per-port request valid.
- i_master_request_ready  input  MASTERS  per-port request ready.
- o_master_request_write, o_master_request_address, o_master_request_data  output  1/ADDRESS_WIDTH/DATA_WIDTH  request payload, broadcast to all ports.
- i_master_response_valid  input  MASTERS  per-port response valid.
- o_master_response_ready  output  MASTERS  per-port response ready.
- i_master_response_data  input  MASTERS*DATA_WIDTH  per-port read data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_master_response_error  input  MASTERS  per-port error status.

Function
REQ-007 SHALL compute target index T = i_request_address[ADDRESS_WIDTH-1 -: SELECT_WIDTH]; T >= MASTERS marks the request unmapped.
REQ-008 SHALL forward requests combinationally with zero latency: o_master_request_valid[T] = i_request_valid AND NOT full; all other bits 0. The payload SHALL equal the upstream payload.
REQ-009 SHALL drive o_request_ready as follows:
- mapped: i_master_request_ready[T] AND NOT full.
- unmapped: NOT full.
REQ-010 SHALL hold an in-order outstanding queue of depth MAX_OUTSTANDING. Each entry stores the target index and an unmapped flag. An entry is pushed on each upstream request handshake.
REQ-011 SHALL assert full when the entry count equals MAX_OUTSTANDING. Full SHALL block new requests even when a response pops in the same cycle.
REQ-012 SHALL, when the queue is empty, hold o_response_valid = 0 and all o_master_response_ready bits = 0.
REQ-013 SHALL, when the head entry is mapped to port H:
- o_response_valid = i_master_response_valid[H]; data and error taken from port H.
- o_master_response_ready[H] = i_response_ready; all other bits 0.
REQ-014 SHALL stall responses from non-head ports until their entry reaches the head; these responses are never dropped or reordered.
REQ-015 SHALL, when the head entry is unmapped, drive o_response_valid = 1, o_response_data = 0, o_response_error = 1, and all o_master_response_ready bits = 0.
REQ-016 SHALL pop the head entry on the upstream response handshake (o_response_valid AND i_response_ready).
REQ-017 SHALL support push and pop in the same cycle: count unchanged, pointers wrap modulo MAX_OUTSTANDING.
REQ-018 SHALL allow a request to be issued and its response returned in the same cycle as the push only for later cycles; the earliest response is one cycle after the request handshake.

Reset
REQ-019 SHALL, while i_rst_n = 0 and asynchronously, clear the queue (count 0, pointers 0).
REQ-020 SHALL, during reset, drive o_response_valid = 0 and all o_master_response_ready bits = 0. o_request_ready then follows REQ-009 with full = 0.
REQ-021 SHALL, when reset is asserted mid-operation, discard all outstanding entries. Late downstream responses after reset are not forwarded while the queue is empty.

Verification
REQ-022 Read to 0x4000_0000 (T=1), port 1 ready, response 0xDEAD_BEEF one cycle later -> o_master_request_valid = 2'b10, upstream response data 0xDEAD_BEEF, error 0.
REQ-023 Write to 0xC000_0000 (T=3, unmapped) -> o_request_ready = 1, no port valid; next cycle o_response_valid = 1, data 0, error 1.
REQ-024 Request port 0, then port 1; port 1 responds first -> port 1 response held with o_master_response_ready[1] = 0 until port 0's response is accepted; upstream order is port 0, then port 1.
REQ-025 Issue 4 requests with i_response_ready = 0 -> fifth request sees o_request_ready = 0; after one response handshake the fifth is accepted; 12 mixed transactions exercise pointer wrap.
REQ-026 Assert i_rst_n = 0 with 3 outstanding -> queue is empty and o_response_valid = 0 immediately; a subsequent request behaves as after power-up.

Source files
------------

// File: rtl/bus_decoder.sv
// Address-decoding request router with an in-order outstanding queue that
// steers responses back upstream in issue order; unmapped targets answer with an error.
module bus_decoder #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MASTERS         = 2,
  parameter int SELECT_WIDTH    = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_request_valid,
  output logic                          o_request_ready,
  input  logic                          i_request_write,
  input  logic [ADDRESS_WIDTH-1:0]      i_request_address,
  input  logic [DATA_WIDTH-1:0]         i_request_data,
  output logic                          o_response_valid,
  input  logic                          i_response_ready,
  output logic [DATA_WIDTH-1:0]         o_response_data,
  output logic                          o_response_error,
  output logic [MASTERS-1:0]            o_master_request_valid,
  input  logic [MASTERS-1:0]            i_master_request_ready,
  output logic                          o_master_request_write,
  output logic [ADDRESS_WIDTH-1:0]      o_master_request_address,
  output logic [DATA_WIDTH-1:0]         o_master_request_data,
  input  logic [MASTERS-1:0]            i_master_response_valid,
  output logic [MASTERS-1:0]            o_master_response_ready,
  input  logic [MASTERS*DATA_WIDTH-1:0] i_master_response_data,
  input  logic [MASTERS-1:0]            i_master_response_error
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic [MAX_OUTSTANDING-1:0][SELECT_WIDTH-1:0] r_q_idx;
  logic [MAX_OUTSTANDING-1:0]                   r_q_unm;
  logic [PW-1:0]                                r_wr_ptr;
  logic [PW-1:0]                                r_rd_ptr;
  logic [CW-1:0]                                r_count;

  logic                    w_full;
  logic                    w_empty;
  logic [SELECT_WIDTH-1:0] w_tgt;
  logic                    w_mapped;
  logic                    w_tgt_ready;
  logic [SELECT_WIDTH-1:0] w_head_idx;
  logic                    w_head_unm;
  logic                    w_push;
  logic                    w_pop;

  assign w_full     = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty    = (r_count == '0);
  assign w_tgt      = i_request_address[ADDRESS_WIDTH-1 -: SELECT_WIDTH];
  assign w_mapped   = (int'(w_tgt) < MASTERS);
  assign w_head_idx = r_q_idx[r_rd_ptr];
  assign w_head_unm = r_q_unm[r_rd_ptr];

  assign o_master_request_write   = i_request_write;
  assign o_master_request_address = i_request_address;
  assign o_master_request_data    = i_request_data;

  always_comb begin
    o_master_request_valid = '0;
    w_tgt_ready            = 1'b0;
    for (int k = 0; k < MASTERS; k++) begin
      if (w_mapped && int'(w_tgt) == k) begin
        o_master_request_valid[k] = i_request_valid && !w_full;
        w_tgt_ready               = i_master_request_ready[k];
      end
    end
    // Unmapped requests are absorbed locally; the queue answers them with an error.
    o_request_ready = !w_full && (w_mapped ? w_tgt_ready : 1'b1);
  end

  assign w_push = i_request_valid && o_request_ready;

  always_comb begin
    o_response_valid        = 1'b0;
    o_response_data         = '0;
    o_response_error        = 1'b0;
    o_master_response_ready = '0;
    if (!w_empty) begin
      if (w_head_unm) begin
        o_response_valid = 1'b1;
        o_response_error = 1'b1;
      end else begin
        // Only the head's port is listened to, so later responses wait in place.
        for (int k = 0; k < MASTERS; k++) begin
          if (int'(w_head_idx) == k) begin
            o_response_valid           = i_master_response_valid[k];
            o_response_data            = i_master_response_data[k*DATA_WIDTH +: DATA_WIDTH];
            o_response_error           = i_master_response_error[k];
            o_master_response_ready[k] = i_response_ready;
          end
        end
      end
    end
  end

  assign w_pop = o_response_valid && i_response_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q_idx  <= '0;
      r_q_unm  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_idx[r_wr_ptr] <= w_tgt;
        r_q_unm[r_wr_ptr] <= !w_mapped;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
